// File: rtl/sudoku_group_seq.sv
// sudoku_group_seq: sequences one elimination pass over a 9-cell Sudoku group.
// GATHER reads each cell's solved value onto the shared bus and accumulates
// a digit mask. APPLY broadcasts ~mask as the remaining candidates. COMMIT
// samples singleton cells. FINISH pulses done.
// Optional feature macro: SUDOKU_SEQ_CONFLICT_EN. When it is defined,
// duplicate solved digits raise conflict, and the pass skips APPLY/COMMIT.
//
//   state  | meaning
//   IDLE   | waiting for start
//   GATHER | reading cell idx (0..8) onto the bus, accumulating mask
//   APPLY  | driving ~mask to all cells with latch_valid
//   COMMIT | latch_singleton strobe, sampling promoted cells into changed
//   FINISH | one-cycle done pulse
module sudoku_group_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       changed,
  output logic       conflict,
  output logic [1:0] cell_addr,
  output logic [8:0] cell_oe,
  output logic       cell_we,
  output logic       latch_valid,
  output logic       latch_singleton,
  input  logic [8:0] bus_in,
  output logic [8:0] bus_out,
  output logic       bus_drive,
  input  logic [8:0] singleton_in,
  input  logic [8:0] solved_in
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_GATHER = 3'd1;
  localparam logic [2:0] S_APPLY  = 3'd2;
  localparam logic [2:0] S_COMMIT = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  localparam logic [3:0] LAST_IDX = 4'd8;

  logic [2:0] state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [8:0] mask_q, mask_d;
  logic       changed_q, changed_d;
`ifdef SUDOKU_SEQ_CONFLICT_EN
  logic       conflict_q, conflict_d;
`endif

  // Next-state and datapath update for the pass sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mask_d    = mask_q;
    changed_d = changed_q;
`ifdef SUDOKU_SEQ_CONFLICT_EN
    conflict_d = conflict_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          mask_d    = 9'd0;
          changed_d = 1'b0;
          idx_d     = 4'd0;
`ifdef SUDOKU_SEQ_CONFLICT_EN
          conflict_d = 1'b0;
`endif
          state_d   = S_GATHER;
        end
      end
      S_GATHER: begin
        mask_d = mask_q | bus_in;
`ifdef SUDOKU_SEQ_CONFLICT_EN
        // A digit already in the mask showing up again is a duplicate.
        conflict_d = conflict_q | (|(mask_q & bus_in));
`endif
        if (idx_q == LAST_IDX) begin
          idx_d = 4'd0;
`ifdef SUDOKU_SEQ_CONFLICT_EN
          // Do not push candidates derived from an inconsistent group.
          state_d = conflict_d ? S_FINISH : S_APPLY;
`else
          state_d = S_APPLY;
`endif
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_APPLY: begin
        state_d = S_COMMIT;
      end
      S_COMMIT: begin
        changed_d = |(singleton_in & ~solved_in);
        state_d   = S_FINISH;
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 4'd0;
      mask_q    <= 9'd0;
      changed_q <= 1'b0;
`ifdef SUDOKU_SEQ_CONFLICT_EN
      conflict_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      mask_q    <= mask_d;
      changed_q <= changed_d;
`ifdef SUDOKU_SEQ_CONFLICT_EN
      conflict_q <= conflict_d;
`endif
    end
  end

  // Strobes decoded from state; gated by reset so an abort silences them at once.
  always_comb begin
    busy            = 1'b0;
    done            = 1'b0;
    cell_oe         = 9'd0;
    bus_drive       = 1'b0;
    bus_out         = 9'd0;
    latch_valid     = 1'b0;
    latch_singleton = 1'b0;
    if (!reset) begin
      busy = (state_q != S_IDLE);
      case (state_q)
        S_GATHER: cell_oe = 9'd1 << idx_q;
        S_APPLY: begin
          bus_drive   = 1'b1;
          bus_out     = ~mask_q;
          latch_valid = 1'b1;
        end
        S_COMMIT: latch_singleton = 1'b1;
        S_FINISH: done = 1'b1;
        default: ;
      endcase
    end
  end

  assign cell_addr = 2'b00;
  assign cell_we   = 1'b0;
  assign changed   = changed_q;
`ifdef SUDOKU_SEQ_CONFLICT_EN
  assign conflict  = conflict_q;
`else
  assign conflict  = 1'b0;
`endif

endmodule

// File: tb/tb_sudoku_group_seq.sv
// Directed bench for sudoku_group_seq. The cells are modelled as a value
// array muxed onto bus_in by cell_oe. Cycle 1 is the first cycle after the
// start-accept edge.
module tb_sudoku_group_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done, changed, conflict;
  logic [1:0] cell_addr;
  logic [8:0] cell_oe;
  logic       cell_we;
  logic       latch_valid, latch_singleton;
  logic [8:0] bus_in, bus_out;
  logic       bus_drive;
  logic [8:0] singleton_in, solved_in;

  logic [8:0] vals [9];

  int n_cmp  = 0;
  int n_fail = 0;

  // per-pass observations
  int         done_cyc, lv_cyc, ls_cyc, lv_cnt, ls_cnt, done_cnt;
  int         oe_err, excl_err, addr_err;
  logic [8:0] apply_bus;

  always #5 clk = ~clk;

  sudoku_group_seq dut (
    .clk(clk), .reset(reset), .start(start),
    .busy(busy), .done(done), .changed(changed), .conflict(conflict),
    .cell_addr(cell_addr), .cell_oe(cell_oe), .cell_we(cell_we),
    .latch_valid(latch_valid), .latch_singleton(latch_singleton),
    .bus_in(bus_in), .bus_out(bus_out), .bus_drive(bus_drive),
    .singleton_in(singleton_in), .solved_in(solved_in)
  );

  always_comb begin
    bus_in = 9'd0;
    for (int i = 0; i < 9; i++)
      if (cell_oe[i]) bus_in = bus_in | vals[i];
  end

  task automatic set_cells(input logic [8:0] v0, v1, v2, v3, v4, v5, v6, v7, v8);
    vals[0] = v0; vals[1] = v1; vals[2] = v2; vals[3] = v3; vals[4] = v4;
    vals[5] = v5; vals[6] = v6; vals[7] = v7; vals[8] = v8;
  endtask

  // Accept a start and observe up to max_c cycles, stopping after done.
  task automatic run_pass(input int max_c);
    logic [8:0] exp_oe;
    done_cyc = 0; lv_cyc = 0; ls_cyc = 0; lv_cnt = 0; ls_cnt = 0; done_cnt = 0;
    oe_err = 0; excl_err = 0; addr_err = 0; apply_bus = 9'h000;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= max_c; c++) begin
      @(negedge clk);
      exp_oe = (c <= 9) ? (9'd1 << (c - 1)) : 9'd0;
      if (cell_oe !== exp_oe) oe_err++;
      if ((int'(cell_oe != 9'd0) + int'(bus_drive) + int'(latch_singleton)) > 1) excl_err++;
      if (cell_addr !== 2'b00 || cell_we !== 1'b0) addr_err++;
      if (latch_valid) begin lv_cnt++; lv_cyc = c; apply_bus = bus_out; end
      if (latch_singleton) begin ls_cnt++; ls_cyc = c; end
      if (done) begin done_cnt++; done_cyc = c; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({busy, done, cell_oe, bus_drive, latch_valid, latch_singleton, bus_out} !== 23'd0) begin
      n_fail++;
      $display("FAIL reset_strobes: got busy=%b done=%b oe=%h drv=%b lv=%b ls=%b bus=%h want all 0",
               busy, done, cell_oe, bus_drive, latch_valid, latch_singleton, bus_out);
    end
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, changed, conflict} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags: got busy=%b changed=%b conflict=%b want 000", busy, changed, conflict);
    end
  endtask

  task automatic test_basic;
    set_cells(9'h001, 9'h002, 9'h004, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0);
    singleton_in = 9'h000; solved_in = 9'h000;
    run_pass(20);
    n_cmp++;
    if (apply_bus !== 9'h1F8) begin n_fail++; $display("FAIL basic_bus_out: got %h want 1f8", apply_bus); end
    n_cmp++;
    if (lv_cyc !== 10 || lv_cnt !== 1) begin
      n_fail++; $display("FAIL basic_latch_valid: got cyc=%0d cnt=%0d want cyc=10 cnt=1", lv_cyc, lv_cnt);
    end
    n_cmp++;
    if (done_cyc !== 12) begin n_fail++; $display("FAIL basic_done_cycle: got %0d want 12", done_cyc); end
    n_cmp++;
    if (oe_err !== 0) begin n_fail++; $display("FAIL basic_cell_oe_seq: got %0d bad cycles want 0", oe_err); end
    n_cmp++;
    if (excl_err !== 0 || addr_err !== 0) begin
      n_fail++; $display("FAIL basic_exclusive: got excl=%0d addr=%0d want 0 0", excl_err, addr_err);
    end
    n_cmp++;
    if ({conflict, changed} !== 2'b00) begin
      n_fail++; $display("FAIL basic_flags: got conflict=%b changed=%b want 0 0", conflict, changed);
    end
  endtask

  task automatic test_singleton;
    set_cells(9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0);
    singleton_in = 9'h008; solved_in = 9'h000;
    run_pass(20);
    n_cmp++;
    if (ls_cyc !== 11 || ls_cnt !== 1) begin
      n_fail++; $display("FAIL sing_latch: got cyc=%0d cnt=%0d want cyc=11 cnt=1", ls_cyc, ls_cnt);
    end
    n_cmp++;
    if (apply_bus !== 9'h1FF) begin n_fail++; $display("FAIL sing_bus_out: got %h want 1ff", apply_bus); end
    repeat (3) @(negedge clk);
    singleton_in = 9'h000;
    n_cmp++;
    if (changed !== 1'b1) begin n_fail++; $display("FAIL sing_changed_held: got %b want 1", changed); end
    // a solved singleton is not a promotion; new start must clear changed
    singleton_in = 9'h008; solved_in = 9'h008;
    run_pass(20);
    n_cmp++;
    if (changed !== 1'b0) begin n_fail++; $display("FAIL sing_solved_nochange: got %b want 0", changed); end
    singleton_in = 9'h000; solved_in = 9'h000;
  endtask

  task automatic test_conflict;
    set_cells(9'h010, 9'h0, 9'h0, 9'h0, 9'h0, 9'h010, 9'h0, 9'h0, 9'h0);
    singleton_in = 9'h001; solved_in = 9'h000;
    run_pass(20);
`ifdef SUDOKU_SEQ_CONFLICT_EN
    n_cmp++;
    if (conflict !== 1'b1) begin n_fail++; $display("FAIL conf_flag: got %b want 1", conflict); end
    n_cmp++;
    if (done_cyc !== 10) begin n_fail++; $display("FAIL conf_done_cycle: got %0d want 10", done_cyc); end
    n_cmp++;
    if (lv_cnt !== 0 || ls_cnt !== 0 || changed !== 1'b0) begin
      n_fail++; $display("FAIL conf_no_latch: got lv=%0d ls=%0d changed=%b want 0 0 0", lv_cnt, ls_cnt, changed);
    end
`else
    n_cmp++;
    if (conflict !== 1'b0) begin n_fail++; $display("FAIL conf_flag: got %b want 0", conflict); end
    n_cmp++;
    if (done_cyc !== 12) begin n_fail++; $display("FAIL conf_done_cycle: got %0d want 12", done_cyc); end
    n_cmp++;
    if (apply_bus !== 9'h1EF) begin n_fail++; $display("FAIL conf_bus_out: got %h want 1ef", apply_bus); end
`endif
    singleton_in = 9'h000;
    set_cells(9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0);
  endtask

  task automatic test_reset_mid;
    int strobes;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (cell_oe !== 9'h010) begin n_fail++; $display("FAIL mid_at_idx4: got oe=%h want 010", cell_oe); end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, cell_oe, bus_drive, latch_valid, latch_singleton, done} !== 14'd0) begin
      n_fail++; $display("FAIL mid_reset_gate: got busy=%b oe=%h want 0 0", busy, cell_oe);
    end
    @(negedge clk); reset = 1'b0;
    strobes = 0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (busy || done || latch_valid || latch_singleton || bus_drive || cell_oe != 9'd0) strobes++;
    end
    n_cmp++;
    if (strobes !== 0) begin n_fail++; $display("FAIL mid_abort: got %0d active cycles want 0", strobes); end
    run_pass(20);
    n_cmp++;
    if (done_cyc !== 12) begin n_fail++; $display("FAIL mid_restart_done: got %0d want 12", done_cyc); end
  endtask

  task automatic test_busy_start;
    int dn, first;
    dn = 0; first = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done) begin dn++; if (first == 0) first = c; end
      start = (c == 3 || c == 12);
    end
    start = 1'b0;
    n_cmp++;
    if (dn !== 1 || first !== 12) begin
      n_fail++; $display("FAIL busy_start_ignored: got dones=%0d first=%0d want 1 at 12", dn, first);
    end
  endtask

  task automatic test_back_to_back;
    int dn, d1, d2;
    dn = 0; d1 = 0; d2 = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      if (done) begin dn++; if (d1 == 0) d1 = c; else d2 = c; end
    end
    start = 1'b0;
    n_cmp++;
    if (dn !== 2 || d1 !== 12 || d2 !== 25) begin
      n_fail++; $display("FAIL back_to_back: got dones=%0d at %0d,%0d want 2 at 12,25", dn, d1, d2);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_after: got busy=%b want 0", busy); end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    singleton_in = 9'h000; solved_in = 9'h000;
    set_cells(9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0);
    test_reset();
    test_basic();
    test_singleton();
    test_conflict();
    test_reset_mid();
    test_busy_start();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
